traffic_controller: RTL and testbench
=====================================

Name: traffic_controller

Overview:
- Two-way (vertical / horizontal) intersection traffic-light sequencer driven by a slow system tick (nominal 5 Hz clock, 200 ns period in simulation).
- Cycles the two directions through green → yellow → all-red, so that the two directions are never green or yellow at the same time.
- Sits at top level; outputs drive the lamp drivers directly.

Parameters:
- GREEN_CYCLES, 50, clock cycles a direction stays green (10 s at 5 Hz); legal range 1..65535
- YELLOW_CYCLES, 15, clock cycles a direction stays yellow (3 s); legal range 1..65535
- ALL_RED_CYCLES, 5, clock cycles both directions are red between phases (1 s); legal range 1..65535

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- v_light  output  3  vertical lamps, one-hot {red, yellow, green}: 3'b100 red, 3'b010 yellow, 3'b001 green
- h_light  output  3  horizontal lamps, same encoding as v_light

Behaviour:
- Reset and timer:
  - Reset is sampled on a rising clk edge only.
  - While rst=1: state ← RED_BEFORE_V, 16-bit dwell counter ← 0.
  - Outputs during and immediately after reset: v_light=100, h_light=100.
- Six-state Moore FSM. Outputs are decoded combinationally from the state register only, with no extra output latency:
  - RED_BEFORE_V: v=100, h=100, dwell ALL_RED_CYCLES, next V_GREEN
  - V_GREEN: v=001, h=100, dwell GREEN_CYCLES, next V_YELLOW
  - V_YELLOW: v=010, h=100, dwell YELLOW_CYCLES, next RED_BEFORE_H
  - RED_BEFORE_H: v=100, h=100, dwell ALL_RED_CYCLES, next H_GREEN
  - H_GREEN: v=100, h=001, dwell GREEN_CYCLES, next H_YELLOW
  - H_YELLOW: v=100, h=010, dwell YELLOW_CYCLES, next RED_BEFORE_V
- Dwell rule:
  - The counter increments each cycle while in a state.
  - When counter == dwell−1, the next edge moves to the next state and clears the counter.
  - Each state therefore holds exactly its dwell count of cycles. Dwell of 1 means one cycle.
- Full period = 2·(GREEN+YELLOW+ALL_RED) = 140 cycles at defaults.
- First vertical green appears ALL_RED_CYCLES edges after the first edge with rst=0. Horizontal green starts (GREEN+YELLOW+ALL_RED) cycles after vertical green starts.
- Safety invariants, required every cycle:
  - At least one direction is red.
  - Each output is exactly one-hot.
  - Never green→red directly; never red→yellow.
- Illegal or unreachable state encodings go to RED_BEFORE_V with counter 0 on the next edge. Outputs in an illegal state are 100/100.
- Reset asserted mid-phase: on the next edge, state ← RED_BEFORE_V and counter ← 0 (outputs 100/100), regardless of current state or count.
- No X on outputs after the first reset edge.

Test Plan:
- Reset hold: rst=1 for 3 edges → v_light=100, h_light=100 throughout. Release; 5 edges later → v=001, h=100.
- Phase timing (defaults):
  - Vertical green for exactly 50 cycles, then v=010 for 15 cycles, then 100/100 for 5 cycles.
  - Then h=001 for 50 cycles, h=010 for 15 cycles, then 100/100 for 5 cycles.
  - Sequence repeats every 140 cycles.
- Long run: 5000 cycles (1 ms at 200 ns) → invariants hold on every cycle: never both non-red, always one-hot, legal transitions only. Exactly 35 complete periods observed.
- Mid-operation reset: assert rst for 1 edge at cycle 20 of H_GREEN → next cycle 100/100. Vertical green resumes 5 cycles after release.
- Minimum parameters GREEN=YELLOW=ALL_RED=1 → 6-cycle period:
  - v_light: 100, 001, 010, 100, 100, 100
  - h_light: 100, 100, 100, 100, 001, 010
- Forced illegal state (via force on the state register) → next edge outputs 100/100 and the sequence restarts from RED_BEFORE_V.

Source files
------------

// File: rtl/traffic_controller.sv
// Two-way intersection light sequencer: each direction runs green -> yellow -> all-red,
// alternating vertical and horizontal, with per-phase dwell times set by parameters.
module traffic_controller #(
  parameter int unsigned GREEN_CYCLES   = 50,
  parameter int unsigned YELLOW_CYCLES  = 15,
  parameter int unsigned ALL_RED_CYCLES = 5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] v_light,
  output logic [2:0] h_light
);

  localparam logic [2:0] RED_BEFORE_V = 3'd0;
  localparam logic [2:0] V_GREEN      = 3'd1;
  localparam logic [2:0] V_YELLOW     = 3'd2;
  localparam logic [2:0] RED_BEFORE_H = 3'd3;
  localparam logic [2:0] H_GREEN      = 3'd4;
  localparam logic [2:0] H_YELLOW     = 3'd5;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  localparam logic [15:0] GREEN_LAST   = 16'(GREEN_CYCLES - 1);
  localparam logic [15:0] YELLOW_LAST  = 16'(YELLOW_CYCLES - 1);
  localparam logic [15:0] ALL_RED_LAST = 16'(ALL_RED_CYCLES - 1);

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [15:0] count;
  logic [15:0] dwell_last;
  logic        state_legal;

  always_comb begin
    state_next  = RED_BEFORE_V;
    dwell_last  = ALL_RED_LAST;
    state_legal = 1'b1;
    case (state)
      RED_BEFORE_V: begin state_next = V_GREEN;      dwell_last = ALL_RED_LAST; end
      V_GREEN:      begin state_next = V_YELLOW;     dwell_last = GREEN_LAST;   end
      V_YELLOW:     begin state_next = RED_BEFORE_H; dwell_last = YELLOW_LAST;  end
      RED_BEFORE_H: begin state_next = H_GREEN;      dwell_last = ALL_RED_LAST; end
      H_GREEN:      begin state_next = H_YELLOW;     dwell_last = GREEN_LAST;   end
      H_YELLOW:     begin state_next = RED_BEFORE_V; dwell_last = YELLOW_LAST;  end
      default:      state_legal = 1'b0;
    endcase
  end

  // The >= only matters if the count was disturbed; in normal flow it fires at count == dwell-1.
  always_ff @(posedge clk) begin
    if (rst || !state_legal) begin
      state <= RED_BEFORE_V;
      count <= '0;
    end else if (count >= dwell_last) begin
      state <= state_next;
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end

  // Lamps decode from the state register alone; anything unrecognised shows red both ways.
  always_comb begin
    v_light = LAMP_RED;
    h_light = LAMP_RED;
    case (state)
      V_GREEN:  v_light = LAMP_GREEN;
      V_YELLOW: v_light = LAMP_YELLOW;
      H_GREEN:  h_light = LAMP_GREEN;
      H_YELLOW: h_light = LAMP_YELLOW;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_traffic_controller.sv
// Bench for traffic_controller: default and minimum-dwell instances checked against
// constant vector tables, directed corner sequences and a position-in-period model.
module tb_traffic_controller;

  localparam int G = 50;
  localparam int Y = 15;
  localparam int A = 5;
  localparam int PERIOD = 2 * (G + Y + A);
  localparam int PERIOD_MIN = 6;
  localparam int LONG_RUN = 5000;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef struct {
    int         k;
    logic [2:0] v;
    logic [2:0] h;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] v_light;
  logic [2:0] h_light;
  logic [2:0] v_min;
  logic [2:0] h_min;

  // Edges with rst=0 since the last reset edge, per instance.
  int k_def = 0;
  int k_min = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [11:0] exp_q[$];

  vec_t min_vecs[7];
  vec_t def_vecs[14];

  traffic_controller dut (
    .clk    (clk),
    .rst    (rst),
    .v_light(v_light),
    .h_light(h_light)
  );

  traffic_controller #(
    .GREEN_CYCLES  (1),
    .YELLOW_CYCLES (1),
    .ALL_RED_CYCLES(1)
  ) dut_min (
    .clk    (clk),
    .rst    (rst),
    .v_light(v_min),
    .h_light(h_min)
  );

  always #100 clk = ~clk;

  // Lights as a function of position in the repeating period.
  function automatic logic [5:0] model_lights(input int k, input int g, input int y, input int a);
    int p;
    p = k % (2 * (g + y + a));
    if (p < a) return {RED, RED};
    p = p - a;
    if (p < g) return {GRN, RED};
    p = p - g;
    if (p < y) return {YEL, RED};
    p = p - y;
    if (p < a) return {RED, RED};
    p = p - a;
    if (p < g) return {RED, GRN};
    return {RED, YEL};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      k_def = 0;
      k_min = 0;
    end else begin
      k_def++;
      k_min++;
    end
    @(negedge clk);
  endtask

  task automatic check_lights(input string tag, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: v_light=%b h_light=%b, expected v_light=%b h_light=%b",
               tag, act[5:3], act[2:0], exp[5:3], exp[2:0]);
    end
  endtask

  task automatic compare_model(input string tag);
    logic [11:0] e;
    exp_q.push_back({model_lights(k_def, G, Y, A), model_lights(k_min, 1, 1, 1)});
    e = exp_q.pop_front();
    check_lights({tag, "_def"}, {v_light, h_light}, e[11:6]);
    check_lights({tag, "_min"}, {v_min, h_min}, e[5:0]);
  endtask

  task automatic check_safety(input string tag, input logic [5:0] prev, input logic [5:0] cur);
    logic ok;
    ok = $onehot(cur[5:3]) && $onehot(cur[2:0]) && (cur[5] || cur[2]);
    ok = ok && !((prev[5:3] == GRN && cur[5:3] == RED) || (prev[2:0] == GRN && cur[2:0] == RED));
    ok = ok && !((prev[5:3] == RED && cur[5:3] == YEL) || (prev[2:0] == RED && cur[2:0] == YEL));
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: lights %b -> %b, required one-hot, one direction red, legal step",
               tag, prev, cur);
    end
  endtask

  task automatic check_count(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  initial begin
    logic [5:0] prev_def;
    logic [5:0] prev_min;
    logic [5:0] cur_def;
    logic [5:0] cur_min;
    int done_def;
    int done_min;

    min_vecs[0] = '{0, RED, RED};
    min_vecs[1] = '{1, GRN, RED};
    min_vecs[2] = '{2, YEL, RED};
    min_vecs[3] = '{3, RED, RED};
    min_vecs[4] = '{4, RED, GRN};
    min_vecs[5] = '{5, RED, YEL};
    min_vecs[6] = '{6, RED, RED};

    def_vecs[0]  = '{0,   RED, RED};
    def_vecs[1]  = '{4,   RED, RED};
    def_vecs[2]  = '{5,   GRN, RED};
    def_vecs[3]  = '{54,  GRN, RED};
    def_vecs[4]  = '{55,  YEL, RED};
    def_vecs[5]  = '{69,  YEL, RED};
    def_vecs[6]  = '{70,  RED, RED};
    def_vecs[7]  = '{74,  RED, RED};
    def_vecs[8]  = '{75,  RED, GRN};
    def_vecs[9]  = '{124, RED, GRN};
    def_vecs[10] = '{125, RED, YEL};
    def_vecs[11] = '{139, RED, YEL};
    def_vecs[12] = '{140, RED, RED};
    def_vecs[13] = '{145, GRN, RED};

    // Reset hold
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_lights($sformatf("reset_hold%0d_def", i), {v_light, h_light}, {RED, RED});
      check_lights($sformatf("reset_hold%0d_min", i), {v_min, h_min}, {RED, RED});
    end
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      while (k_min < min_vecs[i].k) tick();
      check_lights($sformatf("min_vec%0d", i), {v_min, h_min}, {min_vecs[i].v, min_vecs[i].h});
    end

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      while (k_def < def_vecs[i].k) tick();
      check_lights($sformatf("def_vec%0d_k%0d", i, def_vecs[i].k), {v_light, h_light},
                   {def_vecs[i].v, def_vecs[i].h});
    end

    // Reset at cycle 20 of horizontal green
    while (k_def < PERIOD + A + G + Y + A + 20) tick();
    check_lights("mid_reset_before", {v_light, h_light}, {RED, GRN});
    rst = 1'b1;
    tick();
    check_lights("mid_reset_edge", {v_light, h_light}, {RED, RED});
    rst = 1'b0;
    for (int i = 1; i <= A; i++) begin
      tick();
      check_lights($sformatf("mid_reset_release%0d", i), {v_light, h_light},
                   (i < A) ? {RED, RED} : {GRN, RED});
    end

    // Illegal state encoding
    while (k_def < 30) tick();
    force dut.state = 3'b110;
    #1;
    check_lights("illegal_state_outputs", {v_light, h_light}, {RED, RED});
    release dut.state;
    tick();
    k_def = 0;
    check_lights("illegal_state_recover", {v_light, h_light}, {RED, RED});
    for (int i = 1; i <= A; i++) begin
      tick();
      compare_model($sformatf("illegal_restart%0d", i));
    end
    check_lights("illegal_restart_green", {v_light, h_light}, {GRN, RED});

    // Random resets against the model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      tick();
      compare_model("random");
    end
    rst = 1'b0;

    // Long run from a fresh reset: model, invariants, completed periods
    rst = 1'b1;
    tick();
    rst = 1'b0;
    prev_def = {RED, RED};
    prev_min = {RED, RED};
    done_def = 0;
    done_min = 0;
    for (int c = 1; c <= LONG_RUN; c++) begin
      tick();
      cur_def = {v_light, h_light};
      cur_min = {v_min, h_min};
      compare_model("long");
      check_safety("safety_def", prev_def, cur_def);
      check_safety("safety_min", prev_min, cur_min);
      if (prev_def[2:0] == YEL && cur_def[2:0] == RED) done_def++;
      if (prev_min[2:0] == YEL && cur_min[2:0] == RED) done_min++;
      prev_def = cur_def;
      prev_min = cur_min;
    end
    check_count("periods_def", done_def, LONG_RUN / PERIOD);
    check_count("periods_min", done_min, LONG_RUN / PERIOD_MIN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
